fd_scan_engine: RTL and testbench

- Parametrised FAST-N corner scanner.
- On a start pulse it rasters every interior pixel of a frame held in single-port image SRAM.
- For each pixel it fetches the centre plus the 16-pixel Bresenham ring (radius 3), applies the contiguous-arc test against a threshold, and streams corner coordinates out through a valid/ready handshake.
- It sits between the image SRAM and downstream non-max suppression / descriptor logic. It generalises the fixed single-point FAST-9 datapath to configurable frame size, pixel width and arc length, with autonomous scanning and backpressure.

---
 rtl/fd_scan_engine.sv | 238 +++++++++++++++++++++++
 tb/tb_fd_scan_engine.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fd_scan_engine.sv
// fd_scan_engine: FAST-N corner scanner. Rasters every interior pixel of a
// frame held in single-port SRAM, fetches centre + 16-pixel radius-3 ring,
// runs the contiguous-arc test and streams corner coordinates out over a
// valid/ready handshake.
// Optional build macro FD_SCORE_EN adds corner_score (longest same-class run).
`timescale 1ns/1ps
module fd_scan_engine #(
  parameter int IMG_W   = 160,
  parameter int IMG_H   = 120,
  parameter int PIX_W   = 8,
  parameter int ARC_LEN = 9,
  parameter int RD_LAT  = 1,
  localparam int ADDR_W = $clog2(IMG_W*IMG_H),
  localparam int XW     = $clog2(IMG_W),
  localparam int YW     = $clog2(IMG_H)
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              start,
  input  logic [PIX_W-1:0]  thres,
  output logic              busy,
  output logic              done,
  output logic              mem_rden,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_q,
  output logic              corner_valid,
  input  logic              corner_ready,
  output logic [XW-1:0]     corner_x,
  output logic [YW-1:0]     corner_y
`ifdef FD_SCORE_EN
  ,
  output logic [4:0]        corner_score
`endif
);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, EVAL, EMIT, NEXT} scanState_t;

  localparam logic [XW-1:0] X_FIRST    = XW'(3);
  localparam logic [XW-1:0] X_LAST     = XW'(IMG_W-4);
  localparam logic [YW-1:0] Y_FIRST    = YW'(3);
  localparam logic [YW-1:0] Y_LAST     = YW'(IMG_H-4);
  localparam logic [4:0]    FETCH_LAST = 5'd16;
  localparam logic [4:0]    DRAIN_LAST = 5'(RD_LAT-1);

  scanState_t        state, nextState;
  logic [4:0]        cnt;
  logic [XW-1:0]     xPos;
  logic [YW-1:0]     yPos;
  logic [PIX_W-1:0]  thrReg;
  logic [PIX_W-1:0]  regFile [17];
  logic              rdVld_p  [RD_LAT];
  logic [4:0]        rdSlot_p [RD_LAT];
  logic [15:0]       brightVec, darkVec;
  logic [4:0]        brightRun, darkRun;
  logic              isCorner;
  logic              lastPixel;

  // Column offset of ring point k (clockwise from the top).
  function automatic logic signed [2:0] ringDx(input logic [3:0] k);
    logic signed [2:0] d;
    case (k)
      4'd0, 4'd8:        d = 3'sd0;
      4'd1, 4'd7:        d = 3'sd1;
      4'd2, 4'd6:        d = 3'sd2;
      4'd3, 4'd4, 4'd5:  d = 3'sd3;
      4'd9, 4'd15:       d = -3'sd1;
      4'd10, 4'd14:      d = -3'sd2;
      default:           d = -3'sd3;
    endcase
    return d;
  endfunction

  // Row offset of ring point k.
  function automatic logic signed [2:0] ringDy(input logic [3:0] k);
    logic signed [2:0] d;
    case (k)
      4'd0, 4'd1, 4'd15: d = -3'sd3;
      4'd2, 4'd14:       d = -3'sd2;
      4'd3, 4'd13:       d = -3'sd1;
      4'd4, 4'd12:       d = 3'sd0;
      4'd5, 4'd11:       d = 3'sd1;
      4'd6, 4'd10:       d = 3'sd2;
      default:           d = 3'sd3;
    endcase
    return d;
  endfunction

  // Slot 0 is the centre, slots 1..16 are ring points 0..15. The offset is
  // sign-extended and added modulo the coordinate width; interior scan bounds
  // keep every result inside the frame.
  function automatic logic [ADDR_W-1:0] slotAddr(input logic [XW-1:0] px,
                                                 input logic [YW-1:0] py,
                                                 input logic [4:0]    s);
    logic [XW-1:0] ax;
    logic [YW-1:0] ay;
    logic [3:0]    k;
    k  = 4'(s - 5'd1);
    ax = px;
    ay = py;
    if (s != 5'd0) begin
      ax = px + XW'(ringDx(k));
      ay = py + YW'(ringDy(k));
    end
    return ADDR_W'(ay) * ADDR_W'(IMG_W) + ADDR_W'(ax);
  endfunction

  // Longest circular run of set bits; scanning the ring twice covers the wrap.
  function automatic logic [4:0] longestRun(input logic [15:0] v);
    logic [4:0] run, best;
    run  = '0;
    best = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i[3:0]]) begin
        if (run != 5'd16) run = run + 5'd1;
      end else begin
        run = '0;
      end
      if (run > best) best = run;
    end
    return best;
  endfunction

  assign lastPixel = (xPos == X_LAST) && (yPos == Y_LAST);

  // Bright/dark classification in PIX_W+1 bits, then the arc test.
  always_comb begin
    brightVec = '0;
    darkVec   = '0;
    for (int k = 0; k < 16; k++) begin
      brightVec[k] = {1'b0, regFile[k+1]} > ({1'b0, regFile[0]} + {1'b0, thrReg});
      darkVec[k]   = ({1'b0, regFile[k+1]} + {1'b0, thrReg}) < {1'b0, regFile[0]};
    end
    brightRun = longestRun(brightVec);
    darkRun   = longestRun(darkVec);
    isCorner  = (brightRun >= 5'(ARC_LEN)) || (darkRun >= 5'(ARC_LEN));
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!nReset) state <= IDLE;
    else         state <= nextState;
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start && !busy) nextState = FETCH;
      FETCH:   if (cnt == FETCH_LAST) nextState = DRAIN;
      DRAIN:   if (cnt == DRAIN_LAST) nextState = EVAL;
      EVAL:    nextState = isCorner ? EMIT : NEXT;
      EMIT:    if (corner_ready) nextState = NEXT;
      NEXT:    nextState = lastPixel ? IDLE : FETCH;
      default: nextState = IDLE;
    endcase
  end

  // SRAM request outputs: one read per FETCH cycle, address idles at 0.
  always_comb begin
    mem_rden = (state == FETCH);
    mem_addr = mem_rden ? slotAddr(xPos, yPos, cnt) : '0;
  end

  // Phase counter restarts on every state change; raster position advances in NEXT.
  always_ff @(posedge clock) begin
    if (!nReset) begin
      cnt  <= '0;
      xPos <= '0;
      yPos <= '0;
    end else begin
      cnt <= (state != nextState) ? 5'd0 : cnt + 5'd1;
      if (state == IDLE && nextState == FETCH) begin
        xPos <= X_FIRST;
        yPos <= Y_FIRST;
      end else if (state == NEXT && !lastPixel) begin
        if (xPos == X_LAST) begin
          xPos <= X_FIRST;
          yPos <= yPos + YW'(1);
        end else begin
          xPos <= xPos + XW'(1);
        end
      end
    end
  end

  // Threshold is latched on start acceptance.
  always_ff @(posedge clock) begin
    if (state == IDLE && start) thrReg <= thres;
  end

  // Read-return tracking: valid bits travel RD_LAT stages alongside the slot.
  always_ff @(posedge clock) begin
    if (!nReset) begin
      for (int i = 0; i < RD_LAT; i++) rdVld_p[i] <= 1'b0;
    end else begin
      rdVld_p[0] <= mem_rden;
      for (int i = 1; i < RD_LAT; i++) rdVld_p[i] <= rdVld_p[i-1];
    end
  end

  // Slot tags and the 17-entry pixel register file.
  always_ff @(posedge clock) begin
    rdSlot_p[0] <= cnt;
    for (int i = 1; i < RD_LAT; i++) rdSlot_p[i] <= rdSlot_p[i-1];
    if (rdVld_p[RD_LAT-1]) regFile[rdSlot_p[RD_LAT-1]] <= mem_q;
  end

  // Status and corner record outputs.
  always_ff @(posedge clock) begin
    if (!nReset) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      corner_valid <= 1'b0;
      corner_x     <= '0;
      corner_y     <= '0;
`ifdef FD_SCORE_EN
      corner_score <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) busy <= 1'b1;
      if (state == EVAL && isCorner) begin
        corner_valid <= 1'b1;
        corner_x     <= xPos;
        corner_y     <= yPos;
`ifdef FD_SCORE_EN
        corner_score <= (brightRun > darkRun) ? brightRun : darkRun;
`endif
      end
      if (state == EMIT && corner_ready) corner_valid <= 1'b0;
      if (state == NEXT && lastPixel) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fd_scan_engine.sv
// Bench for fd_scan_engine on a 16x16 frame: a raster/arc reference model
// builds the expected corner list and scan length; a negedge process checks
// every emitted record against it.
`timescale 1ns/1ps
module tb_fd_scan_engine;
  localparam int W = 16, H = 16, ARC = 9, LAT = 1;

  logic       clock = 1'b0, nReset = 1'b0, start = 1'b0, corner_ready = 1'b1;
  logic [7:0] thres = 8'd0;
  logic       busy, done, mem_rden, corner_valid;
  logic [7:0] mem_addr, mem_q;
  logic [3:0] corner_x, corner_y;
`ifdef FD_SCORE_EN
  logic [4:0] corner_score;
`endif

  fd_scan_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .ARC_LEN(ARC), .RD_LAT(LAT)) dut (
    .clock(clock), .nReset(nReset), .start(start), .thres(thres),
    .busy(busy), .done(done), .mem_rden(mem_rden), .mem_addr(mem_addr),
    .mem_q(mem_q), .corner_valid(corner_valid), .corner_ready(corner_ready),
    .corner_x(corner_x), .corner_y(corner_y)
`ifdef FD_SCORE_EN
    , .corner_score(corner_score)
`endif
  );

  always #5 clock = ~clock;

  // image SRAM with LAT-cycle read latency
  logic [7:0] img [256];
  logic [7:0] qPipe [LAT];
  always @(posedge clock) begin
    qPipe[0] <= mem_rden ? img[mem_addr] : 8'h00;
    for (int i = 1; i < LAT; i++) qPipe[i] <= qPipe[i-1];
  end
  assign mem_q = qPipe[LAT-1];

  int dxs [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int dys [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  int nTests = 0, nFail = 0;
  int cycCnt = 0, doneCount = 0, recCount = 0, tStart = 0, expCyc = 0;
  int qx[$], qy[$], qs[$];

  always @(posedge clock) cycCnt <= cycCnt + 1;

  task automatic chk(input string nm, input int act, input int exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // 1 = bright, 2 = dark, 0 = similar
  function automatic int cls(input int p, input int c, input int t);
    if (p > c + t) return 1;
    if (p + t < c) return 2;
    return 0;
  endfunction

  // longest circular run of one non-zero class around (x,y)
  function automatic int pixScore(input int x, input int y, input int t);
    int cl [16];
    int c, best, n;
    c = int'(img[y*W + x]);
    for (int k = 0; k < 16; k++)
      cl[k] = cls(int'(img[(y + dys[k])*W + x + dxs[k]]), c, t);
    best = 0;
    for (int s = 0; s < 16; s++) begin
      if (cl[s] != 0) begin
        n = 0;
        while (n < 16 && cl[(s + n) % 16] == cl[s]) n++;
        if (n > best) best = n;
      end
    end
    return best;
  endfunction

  task automatic buildModel(input int t);
    int npix, nc, s;
    qx.delete(); qy.delete(); qs.delete();
    npix = 0; nc = 0;
    for (int y = 3; y <= H - 4; y++)
      for (int x = 3; x <= W - 4; x++) begin
        npix++;
        s = pixScore(x, y, t);
        if (s >= ARC) begin
          qx.push_back(x); qy.push_back(y); qs.push_back(s);
          nc++;
        end
      end
    expCyc = npix*(19 + LAT) + nc + 1;
  endtask

  task automatic fillFrame(input int v);
    for (int i = 0; i < 256; i++) img[i] = 8'(v);
  endtask

  task automatic setPix(input int x, input int y, input int v);
    img[y*W + x] = 8'(v);
  endtask

  task automatic setRing(input int cx, input int cy, input int k, input int v);
    img[(cy + dys[k])*W + cx + dxs[k]] = 8'(v);
  endtask

  // called just after a rising edge; returns just after the accepting edge
  task automatic issueStart(input int t);
    start = 1'b1;
    thres = 8'(t);
    buildModel(t);
    @(posedge clock); #1;
    start  = 1'b0;
    thres  = 8'hEE;
    tStart = cycCnt;
  endtask

  task automatic waitDone(output int cyc);
    int guard;
    guard = 0;
    while (!done && guard < 30000) begin
      @(posedge clock); #1;
      guard++;
    end
    chk("done_seen", done, 1);
    cyc = cycCnt - tStart + 1;
  endtask

  // record checker
  always @(negedge clock) begin
    if (done) doneCount <= doneCount + 1;
    if (corner_valid) begin
      chk("no_read_in_emit", mem_rden, 0);
      chk("rec_expected", int'(qx.size() != 0), 1);
      if (qx.size() != 0) begin
        chk("rec_x", corner_x, qx[0]);
        chk("rec_y", corner_y, qy[0]);
`ifdef FD_SCORE_EN
        chk("rec_score", corner_score, qs[0]);
`endif
        if (corner_ready) begin
          void'(qx.pop_front()); void'(qy.pop_front()); void'(qs.pop_front());
          recCount <= recCount + 1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, r0, d0, s, expAddr;
    int arcKs [9] = '{12, 13, 14, 15, 0, 1, 2, 3, 4};
    int arcExp [3] = '{9, 8, 0};

    // reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rden", mem_rden, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", corner_valid, 0);
    chk("rst_x", corner_x, 0);
    chk("rst_y", corner_y, 0);
`ifdef FD_SCORE_EN
    chk("rst_score", corner_score, 0);
`endif
    nReset = 1'b1;
    @(posedge clock); #1;

    // uniform frame: no corners, 100 pixels * 20 cycles + 1
    fillFrame(50);
    r0 = recCount;
    issueStart(20);
    chk("model_uniform_cyc", expCyc, 100*20 + 1);
    chk("busy_after_start", busy, 1);
    waitDone(cyc);
    chk("uniform_cycles", cyc, expCyc);
    chk("uniform_busy_at_done", busy, 0);
    chk("uniform_recs", recCount - r0, 0);
    @(posedge clock); #1;
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);

    // single bright pixel: one record at (8,8), score 16
    fillFrame(50);
    setPix(8, 8, 200);
    r0 = recCount;
    issueStart(20);
    chk("model_single_n", qx.size(), 1);
    if (qx.size() == 1) begin
      chk("model_single_x", qx[0], 8);
      chk("model_single_y", qy[0], 8);
      chk("model_single_score", qs[0], 16);
    end
    waitDone(cyc);
    chk("single_cycles", cyc, expCyc);
    chk("single_left", qx.size(), 0);
    @(posedge clock); #1;
    chk("single_recs", recCount - r0, 1);

    // wrapped arc: 9 bright -> corner, 8 bright -> none, equal to c+t -> none
    for (int v = 0; v < 3; v++) begin
      fillFrame(100);
      for (int i = 0; i < 9; i++)
        if (!(v == 1 && arcKs[i] == 4)) setRing(8, 8, arcKs[i], (v == 2) ? 120 : 130);
      s = pixScore(8, 8, 20);
      chk("model_arc_score", s, arcExp[v]);
      issueStart(20);
      waitDone(cyc);
      chk("arc_cycles", cyc, expCyc);
      chk("arc_left", qx.size(), 0);
      @(posedge clock); #1;
    end

    // backpressure: ready low for 10 EMIT cycles
    fillFrame(50);
    setPix(8, 8, 200);
    corner_ready = 1'b0;
    r0 = recCount;
    issueStart(20);
    d0 = 0;
    while (!corner_valid && d0 < 5000) begin
      @(posedge clock); #1;
      d0++;
    end
    chk("bp_valid_seen", corner_valid, 1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid_hold", corner_valid, 1);
      chk("bp_x_hold", corner_x, 8);
      chk("bp_y_hold", corner_y, 8);
      chk("bp_no_read", mem_rden, 0);
      @(posedge clock); #1;
    end
    corner_ready = 1'b1;
    @(posedge clock); #1;
    chk("bp_valid_cleared", corner_valid, 0);
    chk("bp_next_no_read", mem_rden, 0);
    @(posedge clock); #1;
    chk("bp_resume_rden", mem_rden, 1);
    chk("bp_resume_addr", mem_addr, 8*W + 9);
    waitDone(cyc);
    chk("bp_cycles", cyc, expCyc + 10);
    @(posedge clock); #1;
    chk("bp_recs", recCount - r0, 1);

    // reset mid-FETCH aborts, then a fresh scan from (3,3)
    issueStart(20);
    repeat (4) begin @(posedge clock); #1; end
    chk("abort_pre_rden", mem_rden, 1);
    nReset = 1'b0;
    @(posedge clock); #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rden", mem_rden, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_valid", corner_valid, 0);
    chk("abort_x", corner_x, 0);
    chk("abort_y", corner_y, 0);
    nReset = 1'b1;
    qx.delete(); qy.delete(); qs.delete();
    d0 = doneCount;
    repeat (30) begin @(posedge clock); #1; end
    chk("abort_no_done", doneCount - d0, 0);
    chk("abort_idle", busy, 0);
    r0 = recCount;
    issueStart(20);
    for (int sl = 0; sl < 17; sl++) begin
      expAddr = (sl == 0) ? 3*W + 3 : (3 + dys[sl-1])*W + 3 + dxs[sl-1];
      chk("rescan_rden", mem_rden, 1);
      chk("rescan_addr", mem_addr, expAddr);
      @(posedge clock); #1;
    end
    waitDone(cyc);
    chk("rescan_cycles", cyc, expCyc);
    @(posedge clock); #1;
    chk("rescan_recs", recCount - r0, 1);

    // start while busy is ignored; start in the done cycle is accepted
    issueStart(20);
    repeat (40) begin @(posedge clock); #1; end
    start = 1'b1;
    thres = 8'd200;
    @(posedge clock); #1;
    start = 1'b0;
    chk("busy_start_busy", busy, 1);
    waitDone(cyc);
    chk("busy_start_cycles", cyc, expCyc);
    chk("busy_start_left", qx.size(), 0);
    issueStart(20);
    chk("done_restart_busy", busy, 1);
    chk("done_restart_done", done, 0);
    waitDone(cyc);
    chk("done_restart_cycles", cyc, expCyc);
    chk("done_restart_left", qx.size(), 0);
    @(posedge clock); #1;

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
